param_core: RTL
===============

Name: param_core

Overview:
- Parametrised multi-cycle successor to the single-core processor.
- Data width and PC width are set by parameters.
- Instruction and data memories are reached through valid/acknowledge handshakes, so memory latency is variable.
- Adds an explicit control FSM, a sticky HALT, and a hardwired-zero r0.
- Sits between the instruction ROM and the data RAM as the sole bus master of each.

Parameters:
- DATA_W, 32, datapath, register and data-memory word width (8..32).
- PC_W, 6, program counter / instruction address width (1..12).
- DADDR_W, 12, data-memory address width (1..12).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (equals PC).
- imem_ack  in  1  fetch acknowledge; imem_rdata valid in this cycle.
- imem_rdata  in  20  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  DADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  data acknowledge; dmem_rdata valid on a load ack.
- dmem_rdata  in  DATA_W  load data.
- pc_out  out  PC_W  current PC.
- halted  out  1  core is stopped in HALT.

Behaviour:
- Instruction format:
  - op = [19:16], rd = [15:12], rs1 = [11:8], rs2 = [7:4].
  - imm = [11:0], zero-extended to DATA_W or truncated to PC_W.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2.
  - 6 SHL: rd = rs1 << 1.
  - 7 INC: rd = rs1 + 1.
  - 8 LDI: rd = imm.
  - 9 LD: rd = mem[rs1[DADDR_W-1:0]].
  - 10 ST: mem[rs1] = rs2.
  - 11 JMP: PC = imm[PC_W-1:0].
  - 12 JZ: if Z then PC = imm.
  - 13 HALT.
  - 14, 15: execute as NOP.
- Arithmetic: all arithmetic is modulo 2^DATA_W, with no carry out. The PC increments modulo 2^PC_W, so PC = 2^PC_W - 1 wraps to 0.
- Z flag:
  - Set to (result == 0) by opcodes 1-7 only.
  - LDI, LD, ST, jumps and NOP leave Z unchanged.
- Register file:
  - 16 x DATA_W.
  - Writes to r0 are discarded; r0 always reads 0.
- Reset (rst = 0, asynchronous):
  - State = FETCH, PC = 0, IR = 0, all registers = 0, Z = 0.
  - imem_req = dmem_req = dmem_we = 0, halted = 0.
  - If reset arrives mid-handshake, the request drops immediately; no write completes.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req = 1 with imem_addr = PC, held stable until imem_ack is sampled high.
  - On ack: IR is loaded, PC increments, go to DECODE.
  - imem_req goes low in the cycle after the ack.
- DECODE: register reads latched into operand registers (A, B) → EXEC.
- EXEC:
  - ALU ops and LDI: result latched into AC, Z updated → WB.
  - LD/ST: AR = A[DADDR_W-1:0], DR = B → MEM.
  - JMP: PC = imm → FETCH.
  - JZ: PC = imm if Z else unchanged → FETCH.
  - NOP, 14, 15 → FETCH.
  - HALT → HALT.
- MEM:
  - dmem_req = 1, with dmem_addr, dmem_we and dmem_wdata stable until dmem_ack.
  - ST on ack → FETCH.
  - LD on ack: dmem_rdata is latched into DR → WB.
- WB: rd is written from AC (ALU/LDI) or DR (LD) → FETCH.
- HALT:
  - halted = 1; no further requests.
  - The core stays in HALT until reset.
- Latency with zero-wait acks (ack in the same cycle as req):
  - ALU/LDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - JMP/JZ/NOP: 3 cycles.
- Each wait cycle on an ack adds one cycle.
- Ack without req is ignored.
- Write in WB and read in the following DECODE are never in the same cycle, so no bypass is needed.

Decomposition:
- param_core_pkg holds:
  - opcode localparams;
  - the FSM state encoding;
  - field bit positions.
- Sub-module param_core_regfile: 16-entry, 2 async-read, 1 sync-write, r0 hardwired to zero, reset clears all entries.
- FSM, PC, IR, AC, AR, DR and the ALU live in the top module.

Test Plan:
- Reset and sequencing:
  - Stimulus: reset, then a zero-wait imem feeding LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT.
  - Response: r3 = 8 and Z = 0; halted rises 4+4+4+3 = 15 cycles after reset release; pc_out = 4.
- Handshake stall:
  - Stimulus: imem_ack delayed 3 cycles on every fetch.
  - Response: imem_addr is stable throughout the wait; each instruction takes +3 cycles; results match the zero-wait run.
- Memory access:
  - Stimulus: LDI r4,0x20; LDI r5,0xAB; ST [r4],r5; LD r6,[r4], with dmem_ack delayed 2 cycles.
  - Response: the store shows dmem_we = 1, dmem_addr = 0x20, dmem_wdata = 0xAB; r6 = 0xAB.
- Flags and branch:
  - Stimulus: SUB r7,r1,r1, then JZ 0x3E.
  - Response: Z = 1 and pc_out = 0x3E after the JZ.
  - Repeat with a nonzero SUB: PC falls through.
  - From PC = 0x3F with PC_W = 6, a NOP fetch wraps pc_out to 0.
- r0 and width:
  - Stimulus: with DATA_W = 8, run LDI r0,7; ADD r1,r0,r0; then LDI r2,0xFF; INC r3,r2.
  - Response: r0 = 0; r1 = 0 with Z = 1; r3 = 0 with Z = 1.
- Reset mid-MEM:
  - Stimulus: assert rst while a store has dmem_req high and no ack.
  - Response: dmem_req drops in the same cycle without waiting for a clock edge; PC = 0; registers are cleared.

Source files
------------

// File: rtl/param_core_pkg.sv
// Shared definitions for the parametrised multi-cycle core: instruction fields, opcodes, FSM states.
package param_core_pkg;

    localparam int unsigned INSTR_W = 20;
    localparam int unsigned IMM_W   = 12;
    localparam int unsigned RIDX_W  = 4;
    localparam int unsigned REG_N   = 16;

    localparam int unsigned OP_LSB  = 16;
    localparam int unsigned RD_LSB  = 12;
    localparam int unsigned RS1_LSB = 8;
    localparam int unsigned RS2_LSB = 4;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_LDI  = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_ST   = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_JZ   = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd13;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Extract a 4-bit instruction field starting at bit lsb.
    function automatic logic [3:0] field4(input logic [INSTR_W-1:0] ir, input int unsigned lsb);
        return ir[lsb +: 4];
    endfunction

    // Opcodes that go through the ALU and update Z.
    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_INC);
    endfunction

endpackage

// File: rtl/param_core_regfile.sv
// 16-entry register file: two asynchronous reads, one synchronous write, r0 reads as zero.
module param_core_regfile
    import param_core_pkg::*;
#(
    parameter int unsigned DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RIDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a_c,
    input  logic [RIDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b_c
);

    logic [DATA_W-1:0] regs [REG_N];

    // Write port; writes to r0 are dropped so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a_c = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b_c = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/param_core.sv
// Parametrised multi-cycle core with handshaked instruction and data memory ports.
module param_core
    import param_core_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 6,
    parameter int unsigned DADDR_W = 12
)
(
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    state_t state, state_next;

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  a, b, ac, dr;
    logic [DADDR_W-1:0] ar;
    logic               z;

    logic [3:0]         op, rd, rs1, rs2;
    logic [IMM_W-1:0]   imm;
    logic               alu_op, mem_op;
    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]  rf_a, rf_b, rf_wdata;
    logic               rf_we;

    assign op     = field4(ir, OP_LSB);
    assign rd     = field4(ir, RD_LSB);
    assign rs1    = field4(ir, RS1_LSB);
    assign rs2    = field4(ir, RS2_LSB);
    assign imm    = ir[IMM_LSB +: IMM_W];
    assign alu_op = is_alu(op);
    assign mem_op = (op == OP_LD) || (op == OP_ST);

    param_core_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .waddr     (rd),
        .wdata     (rf_wdata),
        .raddr_a   (rs1),
        .rdata_a_c (rf_a),
        .raddr_b   (rs2),
        .rdata_b_c (rf_b)
    );

    // Write-back source: loads return through DR, everything else through AC.
    assign rf_we    = (state == ST_WB);
    assign rf_wdata = (op == OP_LD) ? dr : ac;

    // Moore outputs decoded from the state register; fetch request is held off while reset is asserted.
    assign imem_req   = rst && (state == ST_FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == ST_MEM);
    assign dmem_we    = (state == ST_MEM) && (op == OP_ST);
    assign dmem_addr  = ar;
    assign dmem_wdata = dr;
    assign pc_out     = pc;
    assign halted     = (state == ST_HALT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  if (imem_ack) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if (alu_op || (op == OP_LDI)) begin
                    state_next = ST_WB;
                end else if (mem_op) begin
                    state_next = ST_MEM;
                end else if (op == OP_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_MEM:    if (dmem_ack) state_next = (op == OP_ST) ? ST_FETCH : ST_WB;
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    // ALU; LDI passes the zero-extended immediate through the same result path.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = a << 1;
            OP_INC:  alu_res = a + DATA_W'(1);
            OP_LDI:  alu_res = DATA_W'(imm);
            default: alu_res = '0;
        endcase
    end

    // Datapath registers: PC, IR, operands, AC, AR, DR and Z.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
            ir <= '0;
            a  <= '0;
            b  <= '0;
            ac <= '0;
            ar <= '0;
            dr <= '0;
            z  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + PC_W'(1);
                    end
                end
                ST_DECODE: begin
                    a <= rf_a;
                    b <= rf_b;
                end
                ST_EXEC: begin
                    if (alu_op || (op == OP_LDI)) ac <= alu_res;
                    if (alu_op) z <= (alu_res == '0);
                    if (mem_op) begin
                        ar <= DADDR_W'(a);
                        dr <= b;
                    end
                    if ((op == OP_JMP) || ((op == OP_JZ) && z)) pc <= PC_W'(imm);
                end
                ST_MEM: begin
                    if (dmem_ack && (op == OP_LD)) dr <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
